// File: rtl/key_load_ctrl.sv
// Key load controller: streams host lines into one key-FIFO slot per polynomial,
// port A lines at {0,line} and port B lines at {1,line}, with slot-finish handshake.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif

module key_load_ctrl #(
    parameter int unsigned LINES_PER_PORT = 2**(`ADDR_WIDTH-1),
    parameter int unsigned POLY_CNT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [POLY_CNT_WIDTH-1:0]            num_polys,
    output logic                                 busy,
    output logic                                 done,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]     in_dA,
    input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]     in_dB,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr_finish,
    output logic                                 fifo_wr_enable,
    output logic [`ADDR_WIDTH-1:0]               fifo_addrA,
    output logic [`ADDR_WIDTH-1:0]               fifo_addrB,
    output logic [`BIT_WIDTH*`LINE_SIZE-1:0]     fifo_dA,
    output logic [`BIT_WIDTH*`LINE_SIZE-1:0]     fifo_dB
);

    localparam int unsigned AW   = `ADDR_WIDTH;
    localparam int unsigned LC_W = (LINES_PER_PORT > 1) ? $clog2(LINES_PER_PORT) : 1;
    localparam logic [LC_W-1:0] LAST_LINE = LC_W'(LINES_PER_PORT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t                    r_state;
    logic [POLY_CNT_WIDTH-1:0] r_poly_rem;
    logic [LC_W-1:0]           r_line_cnt;
    logic                      r_busy;
    logic                      r_in_ready;
    logic                      r_done;

    logic                      w_in_fill;
    logic                      w_beat;
    logic                      w_last_beat;
    logic [AW-1:0]             w_addr_a;
    logic [AW-1:0]             w_addr_b;

    assign w_in_fill   = (r_state == FILL);
    assign w_beat      = w_in_fill && in_valid;
    assign w_last_beat = w_beat && (r_line_cnt == LAST_LINE);
    assign w_addr_a    = AW'({1'b0, r_line_cnt});
    assign w_addr_b    = AW'({1'b1, r_line_cnt});

    // Finish stays high everywhere except FILL so the FIFO only advances on the last write.
    assign fifo_wr_finish = w_in_fill ? w_last_beat : 1'b1;
    assign fifo_wr_enable = w_beat;
    assign fifo_addrA     = w_in_fill ? w_addr_a : '0;
    assign fifo_addrB     = w_in_fill ? w_addr_b : '0;
    assign fifo_dA        = in_dA;
    assign fifo_dB        = in_dB;

    assign busy     = r_busy;
    assign in_ready = r_in_ready;
    assign done     = r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_poly_rem <= '0;
            r_line_cnt <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_polys != '0) begin
                            r_state    <= WAIT_SLOT;
                            r_poly_rem <= num_polys;
                            r_line_cnt <= '0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                WAIT_SLOT: begin
                    if (!fifo_full) begin
                        r_state    <= FILL;
                        r_in_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        if (r_line_cnt == LAST_LINE) begin
                            r_line_cnt <= '0;
                            r_poly_rem <= r_poly_rem - POLY_CNT_WIDTH'(1);
                            r_in_ready <= 1'b0;
                            if (r_poly_rem == POLY_CNT_WIDTH'(1)) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= WAIT_SLOT;
                            end
                        end else begin
                            r_line_cnt <= r_line_cnt + LC_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl: host-beat driver pushes expected FIFO writes,
// a negedge monitor pops and compares them; directed steps cover control timing.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif

module tb_key_load_ctrl;

    localparam int AW      = `ADDR_WIDTH;
    localparam int DW      = `BIT_WIDTH*`LINE_SIZE;
    localparam int LPP     = 4;
    localparam int TIMEOUT = 50;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [7:0]    num_polys;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_dA;
    logic [DW-1:0] in_dB;
    logic          fifo_full;
    logic          fifo_wr_finish;
    logic          fifo_wr_enable;
    logic [AW-1:0] fifo_addrA;
    logic [AW-1:0] fifo_addrB;
    logic [DW-1:0] fifo_dA;
    logic [DW-1:0] fifo_dB;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic          fin;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_rises  = 0;
    int n_done   = 0;
    logic prev_fin = 1'b1;

    key_load_ctrl #(
        .LINES_PER_PORT(LPP),
        .POLY_CNT_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .num_polys     (num_polys),
        .busy          (busy),
        .done          (done),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dA         (in_dA),
        .in_dB         (in_dB),
        .fifo_full     (fifo_full),
        .fifo_wr_finish(fifo_wr_finish),
        .fifo_wr_enable(fifo_wr_enable),
        .fifo_addrA    (fifo_addrA),
        .fifo_addrB    (fifo_addrB),
        .fifo_dA       (fifo_dA),
        .fifo_dB       (fifo_dB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every FIFO write must match the oldest driven beat.
    always @(negedge clk) begin
        if (fifo_wr_enable === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL unexpected_write observed=addrA %0h expected=no write", fifo_addrA);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addrA",  64'(fifo_addrA),     64'(mon_e.a));
                check("wr_addrB",  64'(fifo_addrB),     64'(mon_e.b));
                check("wr_dA",     64'(fifo_dA),        64'(mon_e.da));
                check("wr_dB",     64'(fifo_dB),        64'(mon_e.db));
                check("wr_finish", 64'(fifo_wr_finish), 64'(mon_e.fin));
            end
        end
        if (fifo_wr_finish === 1'b1 && prev_fin === 1'b0) n_rises++;
        prev_fin = fifo_wr_finish;
        if (done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        start     = 1'b1;
        num_polys = n;
        tick();
        start     = 1'b0;
        num_polys = 8'($urandom);
    endtask

    // Present one host beat, hold it until accepted; waits = cycles seen with in_ready low.
    task automatic drive_beat(input int line, input bit last, output int waits);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = DW'({$urandom, $urandom});
        b = DW'({$urandom, $urandom});
        in_valid = 1'b1;
        in_dA    = a;
        in_dB    = b;
        exp_q.push_back('{a: AW'(line), b: AW'(line + LPP), da: a, db: b, fin: last});
        waits = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waits < TIMEOUT) begin
            waits++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $error("FAIL beat_timeout observed=in_ready %b expected=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, "_done_hi"}, 64'(done), 64'd1);
        check({tag, "_busy_lo"}, 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        check({tag, "_done_lo"}, 64'(done), 64'd0);
        tick();
    endtask

    task automatic clear_counts();
        n_writes = 0;
        n_rises  = 0;
        n_done   = 0;
    endtask

    initial begin
        int w;
        rstn      = 1'b0;
        start     = 1'b0;
        num_polys = '0;
        in_valid  = 1'b0;
        in_dA     = '0;
        in_dB     = '0;
        fifo_full = 1'b0;
        #3;
        check("rst_busy",     64'(busy),           64'd0);
        check("rst_done",     64'(done),           64'd0);
        check("rst_in_ready", 64'(in_ready),       64'd0);
        check("rst_finish",   64'(fifo_wr_finish), 64'd1);
        check("rst_wr_en",    64'(fifo_wr_enable), 64'd0);
        check("rst_addrB",    64'(fifo_addrB),     64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single polynomial, continuous valid
        clear_counts();
        do_start(8'd1);
        drive_beat(0, 1'b0, w);
        check("p1_first_wait", 64'(w), 64'd1);
        for (int i = 1; i < LPP; i++) drive_beat(i, (i == LPP - 1), w);
        expect_done("p1");
        check("p1_writes", 64'(n_writes), 64'd4);
        check("p1_rises",  64'(n_rises),  64'd1);
        check("p1_ndone",  64'(n_done),   64'd1);

        // Three polynomials, continuous valid
        clear_counts();
        do_start(8'd3);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < LPP; i++) begin
                drive_beat(i, (i == LPP - 1), w);
                if (i == 0) check("p3_slot_gap", 64'(w), 64'd1);
            end
        end
        expect_done("p3");
        check("p3_writes", 64'(n_writes), 64'd12);
        check("p3_rises",  64'(n_rises),  64'd3);
        check("p3_ndone",  64'(n_done),   64'd1);

        // FIFO full held in WAIT_SLOT
        clear_counts();
        fifo_full = 1'b1;
        do_start(8'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_in_ready", 64'(in_ready),       64'd0);
            check("full_finish",   64'(fifo_wr_finish), 64'd1);
            check("full_wr_en",    64'(fifo_wr_enable), 64'd0);
            check("full_busy",     64'(busy),           64'd1);
            tick();
        end
        fifo_full = 1'b0;
        drive_beat(0, 1'b0, w);
        check("full_release_wait", 64'(w), 64'd1);
        for (int i = 1; i < LPP; i++) drive_beat(i, (i == LPP - 1), w);
        expect_done("full");
        check("full_writes", 64'(n_writes), 64'd4);

        // Toggled valid: stall cycles hold line and keep finish low
        clear_counts();
        do_start(8'd1);
        for (int i = 0; i < LPP; i++) begin
            drive_beat(i, (i == LPP - 1), w);
            if (i < LPP - 1) begin
                @(negedge clk);
                check("stall_wr_en",  64'(fifo_wr_enable), 64'd0);
                check("stall_finish", 64'(fifo_wr_finish), 64'd0);
                check("stall_addrA",  64'(fifo_addrA),     64'(i + 1));
                check("stall_addrB",  64'(fifo_addrB),     64'(i + 1 + LPP));
                tick();
            end
        end
        expect_done("tog");
        check("tog_writes", 64'(n_writes), 64'd4);
        check("tog_rises",  64'(n_rises),  64'd1);

        // Zero polynomials
        clear_counts();
        do_start(8'd0);
        expect_done("zero");
        check("zero_writes", 64'(n_writes), 64'd0);
        check("zero_ndone",  64'(n_done),   64'd1);

        // Start while busy is ignored
        clear_counts();
        do_start(8'd1);
        drive_beat(0, 1'b0, w);
        start     = 1'b1;
        num_polys = 8'd5;
        drive_beat(1, 1'b0, w);
        start     = 1'b0;
        for (int i = 2; i < LPP; i++) drive_beat(i, (i == LPP - 1), w);
        expect_done("ign");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ign_busy_after", 64'(busy), 64'd0);
            tick();
        end
        check("ign_writes", 64'(n_writes), 64'd4);
        check("ign_ndone",  64'(n_done),   64'd1);

        // Reset mid-FILL abandons the slot
        clear_counts();
        do_start(8'd1);
        drive_beat(0, 1'b0, w);
        drive_beat(1, 1'b0, w);
        in_valid = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_busy",     64'(busy),           64'd0);
        check("mid_rst_in_ready", 64'(in_ready),       64'd0);
        check("mid_rst_finish",   64'(fifo_wr_finish), 64'd1);
        check("mid_rst_wr_en",    64'(fifo_wr_enable), 64'd0);
        check("mid_rst_addrA",    64'(fifo_addrA),     64'd0);
        check("mid_rst_done",     64'(done),           64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("mid_rst_ndone", 64'(n_done), 64'd0);
        do_start(8'd1);
        for (int i = 0; i < LPP; i++) drive_beat(i, (i == LPP - 1), w);
        expect_done("post_rst");
        check("post_rst_writes", 64'(n_writes), 64'd6);
        check("post_rst_ndone",  64'(n_done),   64'd1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/key_load_ctrl.md
KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 The block SHALL have parameters: LINES_PER_PORT, default 2**(`ADDR_WIDTH-1), lines written per port per polynomial (SHALL be >= 2); POLY_CNT_WIDTH, default 8, width of the polynomial count.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse that begins a key load
- num_polys  in  POLY_CNT_WIDTH  polynomials to load; sampled on start
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- in_valid  in  1  host beat valid
- in_ready  out  1  host beat accepted when in_valid && in_ready
- in_dA, in_dB  in  `BIT_WIDTH*`LINE_SIZE each  host line data for port A and port B
- fifo_full  in  1  key FIFO full flag
- fifo_wr_finish  out  1  FIFO slot write-finish handshake
- fifo_wr_enable  out  1  FIFO write qualifier
- fifo_addrA, fifo_addrB  out  `ADDR_WIDTH each  slot line addresses
- fifo_dA, fifo_dB  out  `BIT_WIDTH*`LINE_SIZE each  slot write data

Function
REQ-003 The block SHALL implement the FSM states IDLE, WAIT_SLOT and FILL, with registered poly_rem (POLY_CNT_WIDTH bits) and line_cnt ($clog2(LINES_PER_PORT) bits).
REQ-004 IDLE: fifo_wr_finish=1, in_ready=0, busy=0.
- start && num_polys!=0 -> WAIT_SLOT; poly_rem=num_polys; line_cnt=0.
- start && num_polys==0 -> stay in IDLE; done=1 in the next cycle.
REQ-005 In any state other than IDLE, start SHALL be ignored.
REQ-006 WAIT_SLOT: fifo_wr_finish=1, in_ready=0, fifo_wr_enable=0, busy=1.
- fifo_full==0 -> FILL.
- Otherwise stay in WAIT_SLOT.
REQ-007 FILL: in_ready=1, busy=1, fifo_wr_enable=in_valid.
- fifo_addrA = {1'b0, line_cnt}.
- fifo_addrB = {1'b1, line_cnt}, zero-extended to `ADDR_WIDTH.
- fifo_dA=in_dA and fifo_dB=in_dB, combinational pass-through.
REQ-008 In FILL, fifo_wr_finish SHALL be 1 only in the cycle where in_valid && line_cnt==LINES_PER_PORT-1 (finish raised together with the last write); otherwise 0.
REQ-009 Each accepted beat SHALL increment line_cnt; an in_valid=0 stall cycle SHALL hold line_cnt and keep fifo_wr_finish=0.
REQ-010 On the last-line beat: line_cnt SHALL wrap to 0 and poly_rem SHALL decrement.
- If poly_rem was 1 -> IDLE with done=1 in the next cycle.
- Otherwise -> WAIT_SLOT.
REQ-011 Between consecutive polynomials there SHALL be at least one cycle with fifo_wr_finish=1 (WAIT_SLOT), so the FIFO write pointer advances exactly once per polynomial.
REQ-012 Outside FILL: fifo_wr_enable=0, fifo_addrA=0, fifo_addrB=0.
REQ-013 done SHALL be registered, high for exactly one cycle per start that was accepted in IDLE.
REQ-014 The block SHALL never drive fifo_wr_finish=0 while fifo_full=1 was sampled in WAIT_SLOT of the same polynomial.

Reset
REQ-015 rstn=0 SHALL asynchronously force: IDLE, poly_rem=0, line_cnt=0, done=0, busy=0, in_ready=0, fifo_wr_finish=1, fifo_wr_enable=0.
REQ-016 Reset asserted mid-FILL SHALL abandon the partial slot; the FIFO is reset by the same rstn, and no done pulse SHALL be produced.

Verification
REQ-017 LINES_PER_PORT=4, start with num_polys=1, in_valid held 1, FIFO empty:
- fifo_wr_finish low 3 cycles, then high together with the 4th write.
- Addresses A 0..3 and B 4..7 (`ADDR_WIDTH=3).
- done one cycle after the last beat.
REQ-018 num_polys=3 with continuous in_valid: exactly 12 writes and 3 finish rising edges, each separated by exactly one WAIT_SLOT cycle; done once.
REQ-019 fifo_full=1 held for 10 cycles in WAIT_SLOT: in_ready=0 and fifo_wr_finish=1 throughout; FILL entered one cycle after full drops.
REQ-020 in_valid toggled 1,0,1,0: line_cnt and addresses hold during the 0 cycles; finish asserted only on the final valid beat.
REQ-021 start with num_polys=0 -> done one cycle later, busy never 1. A second start during busy -> ignored, with total writes unchanged.
REQ-022 rstn pulsed low after 2 of 4 beats -> outputs at their reset values immediately; a fresh start with num_polys=1 completes normally.
